pc_sequencer: RTL and testbench
===============================

Name:
pc_sequencer

Overview:
- Multi-cycle control FSM for the CPU core. It sequences instruction fetch, decode, execute, memory and writeback.
- It owns the PC update strobes PCWrite and PCSrc[1:0], which feed the PC block directly.
- The PC block's encoding applies: PCSrc[0] selects the branch target (PC+4+imm<<2), PCSrc[1] selects JumpPC, and 00 selects PC+4.
- The PC holds the current instruction address until that instruction's final state, so branch and jump targets are computed from the current PC.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; the FSM updates on the posedge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  6  instr[31:26] from the externally registered IR; valid from ID onward.
- Zero  in  1  ALU zero flag; valid in EXE.
- MemReady  in  1  memory handshake; 1 means the current access completes this cycle.
- PCWrite  out  1  PC update enable; the PC latches on the following negedge.
- PCSrc  out  2  PC next-address select.
- IRWrite  out  1  loads the IR.
- MemRead  out  1  memory read request (instruction or data).
- MemWrite  out  1  data memory write request.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  write-register select: 00=rt, 01=rd, 10=$31.
- MemToReg  out  1  writeback source: 1=memory data, 0=ALU result.
- ALUSrcB  out  1  ALU B operand: 1=sign-extended immediate, 0=rt.
- ALUOp  out  3  000=ADD, 001=SUB, 010=FUNCT.
- State  out  3  current state, for debug.
- Halted  out  1  high in HALT.
- Illegal  out  1  sticky flag: an undefined opcode was decoded.
- RetiredCnt  out  CNT_W  count of completed instructions.

Behaviour:
- Reset, sampled at the posedge:
  - State=IF, Illegal=0, RetiredCnt=0.
  - Reset has priority over every transition, including reset mid-instruction and reset in HALT.
  - While Reset=1, all strobes are forced to 0.
- Outputs are combinational from {State, Opcode, Zero, MemReady}. Every strobe not listed for a state is 0.
- Opcodes: R=000000, ADDIU=001001, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011, HALT=111111.
- IF (000):
  - MemRead=1.
  - If MemReady=1: IRWrite=1, go to ID.
  - Otherwise stay in IF; IRWrite=0.
- ID (001):
  - J: PCWrite=1, PCSrc=10, go to IF.
  - JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, go to IF. The link value is supplied by the datapath.
  - HALT: go to HALT.
  - Undefined opcode: set Illegal=1, go to HALT.
  - Any other opcode: go to EXE.
- EXE (010):
  - R: ALUOp=FUNCT, ALUSrcB=0, go to WB.
  - ADDIU, LW, SW: ALUOp=ADD, ALUSrcB=1. ADDIU goes to WB; LW and SW go to MEM.
  - BEQ/BNE: ALUOp=SUB, ALUSrcB=0, PCWrite=1, go to IF.
  - Branch taken is Zero for BEQ and !Zero for BNE; PCSrc={1'b0, taken}.
- MEM (011):
  - LW: MemRead=1. If MemReady=1 go to WB, else stay.
  - SW: MemWrite=1. If MemReady=1 then PCWrite=1, PCSrc=00, go to IF; else stay, with no PCWrite.
- WB (100):
  - RegWrite=1, PCWrite=1, PCSrc=00, go to IF.
  - LW: MemToReg=1, RegDst=00.
  - ADDIU: MemToReg=0, RegDst=00.
  - R: MemToReg=0, RegDst=01.
- HALT (101):
  - All strobes are 0 and the FSM stays here.
  - HALT is left only by Reset.
- Unused encodings 110/111: go to IF on the next clock, with all strobes 0.
- PCWrite rules:
  - PCWrite is asserted exactly once per completed instruction, and is never asserted in IF or HALT.
  - RetiredCnt increments on every posedge where PCWrite=1.
  - RetiredCnt wraps modulo 2^CNT_W.
- Latency with MemReady=1 throughout: J/JAL 2 cycles, BEQ/BNE 3, R/ADDIU/SW 4, LW 5.
- Each MemReady=0 cycle in IF or MEM adds one cycle to the instruction.
- MemReady is ignored outside IF and MEM.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - opcode constants;
  - state encodings IF..HALT;
  - ALUOp codes;
  - RegDst codes;
  - PCSrc codes: PCSRC_SEQ=00, PCSRC_BR=01, PCSRC_JMP=10.
- One sub-module, pc_seq_decode: a purely combinational block mapping {State, Opcode, Zero, MemReady} to the strobes and next state. The state register and counter stay in the top.

Test Plan:
- Reset held 2 cycles, then released with MemReady=1 and Opcode=R:
  - States are IF,ID,EXE,WB.
  - PCWrite=1 with PCSrc=00 only in WB.
  - WB has RegDst=01.
  - RetiredCnt=1 after 4 cycles.
- LW, with MemReady low for 2 cycles in MEM:
  - MEM lasts 3 cycles.
  - WB follows with MemToReg=1.
  - The instruction takes 7 cycles in total.
- BEQ:
  - With Zero=1: PCSrc=01 in EXE.
  - With Zero=0: PCSrc=00.
  - BNE gives the inverse.
  - Each takes 3 cycles, with one PCWrite.
- JAL:
  - In ID: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10.
  - Next state is IF; 2 cycles in total.
- Opcode 110011:
  - Illegal=1 and Halted=1.
  - No PCWrite for 10 cycles.
  - Reset clears Illegal and returns the FSM to IF.
- SW, with Reset asserted during MEM while MemReady=0:
  - No MemWrite on the reset cycle.
  - State=IF next cycle.
  - RetiredCnt=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
// No logic; constants and the strobe bundle type only.
// Imported by the sequencer, its decoder and the interface.
package cpu_ctrl_pkg;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // FSM state encodings; 110/111 are unused and recover to IF
    localparam logic [2:0] ST_IF   = 3'b000;
    localparam logic [2:0] ST_ID   = 3'b001;
    localparam logic [2:0] ST_EXE  = 3'b010;
    localparam logic [2:0] ST_MEM  = 3'b011;
    localparam logic [2:0] ST_WB   = 3'b100;
    localparam logic [2:0] ST_HALT = 3'b101;

    // ALU operation codes
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    // Write-register select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // PC next-address select, matching the PC block's one-hot-ish encoding
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // All control strobes driven by the sequencer, as one bundle
    typedef struct packed {
        logic       PCWrite;
        logic [1:0] PCSrc;
        logic       IRWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       RegWrite;
        logic [1:0] RegDst;
        logic       MemToReg;
        logic       ALUSrcB;
        logic [2:0] ALUOp;
    } strobes_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bus between the sequencer and the datapath / PC block.
// Signals only; timing is set by the sequencer (combinational strobes).
// MemReady is the only stall input; it is honoured in IF and MEM.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic             MemToReg;
    logic             ALUSrcB;
    logic [2:0]       ALUOp;
    logic [2:0]       State;
    logic             Halted;
    logic             Illegal;
    logic [CNT_W-1:0] RetiredCnt;

    // Datapath side: supplies opcode/flags/handshake, consumes strobes
    modport master (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite,
        input  RegDst, MemToReg, ALUSrcB, ALUOp, State, Halted, Illegal,
        input  RetiredCnt
    );

    // Sequencer side
    modport slave (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite,
        output RegDst, MemToReg, ALUSrcB, ALUOp, State, Halted, Illegal,
        output RetiredCnt
    );
endinterface

// File: rtl/pc_seq_decode.sv
// Next-state and strobe decode for the multi-cycle sequencer.
// Purely combinational, zero latency.
// Stalls by holding state in IF/MEM while mem_ready_i is low.
module pc_seq_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output strobes_t   strb_o,
    output logic [2:0] next_state_o,
    output logic       set_illegal_o
);

    // Per-state strobe generation and transition selection
    always_comb begin
        strb_o        = '0;
        next_state_o  = state_i;
        set_illegal_o = 1'b0;
        case (state_i)
            ST_IF: begin
                strb_o.MemRead = 1'b1;
                if (mem_ready_i) begin
                    strb_o.IRWrite = 1'b1;
                    next_state_o   = ST_ID;
                end
            end
            ST_ID: begin
                case (opcode_i)
                    OP_J: begin
                        strb_o.PCWrite = 1'b1;
                        strb_o.PCSrc   = PCSRC_JMP;
                        next_state_o   = ST_IF;
                    end
                    OP_JAL: begin
                        // Link value comes from the datapath; only steer it to $31
                        strb_o.PCWrite  = 1'b1;
                        strb_o.PCSrc    = PCSRC_JMP;
                        strb_o.RegWrite = 1'b1;
                        strb_o.RegDst   = REGDST_RA;
                        next_state_o    = ST_IF;
                    end
                    OP_HALT: next_state_o = ST_HALT;
                    OP_R, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                        next_state_o = ST_EXE;
                    default: begin
                        set_illegal_o = 1'b1;
                        next_state_o  = ST_HALT;
                    end
                endcase
            end
            ST_EXE: begin
                next_state_o = ST_IF;
                case (opcode_i)
                    OP_R: begin
                        strb_o.ALUOp = ALUOP_FUNCT;
                        next_state_o = ST_WB;
                    end
                    OP_ADDIU: begin
                        strb_o.ALUOp   = ALUOP_ADD;
                        strb_o.ALUSrcB = 1'b1;
                        next_state_o   = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        strb_o.ALUOp   = ALUOP_ADD;
                        strb_o.ALUSrcB = 1'b1;
                        next_state_o   = ST_MEM;
                    end
                    OP_BEQ: begin
                        // PC still holds this instruction, so the target is PC+4+imm<<2
                        strb_o.ALUOp   = ALUOP_SUB;
                        strb_o.PCWrite = 1'b1;
                        strb_o.PCSrc   = {1'b0, zero_i};
                    end
                    OP_BNE: begin
                        strb_o.ALUOp   = ALUOP_SUB;
                        strb_o.PCWrite = 1'b1;
                        strb_o.PCSrc   = {1'b0, ~zero_i};
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                next_state_o = ST_IF;
                case (opcode_i)
                    OP_LW: begin
                        strb_o.MemRead = 1'b1;
                        next_state_o   = mem_ready_i ? ST_WB : ST_MEM;
                    end
                    OP_SW: begin
                        // Store retires here; PC advances only once the write lands
                        strb_o.MemWrite = 1'b1;
                        if (mem_ready_i) begin
                            strb_o.PCWrite = 1'b1;
                            strb_o.PCSrc   = PCSRC_SEQ;
                        end else begin
                            next_state_o = ST_MEM;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                strb_o.RegWrite = 1'b1;
                strb_o.PCWrite  = 1'b1;
                strb_o.PCSrc    = PCSRC_SEQ;
                next_state_o    = ST_IF;
                case (opcode_i)
                    OP_LW: begin
                        strb_o.MemToReg = 1'b1;
                        strb_o.RegDst   = REGDST_RT;
                    end
                    OP_R:    strb_o.RegDst = REGDST_RD;
                    default: strb_o.RegDst = REGDST_RT;
                endcase
            end
            ST_HALT: next_state_o = ST_HALT;
            default: next_state_o = ST_IF;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB with retire counter.
// Strobes are combinational from state and inputs; state updates each posedge.
// MemReady low stretches IF or MEM by one cycle per low cycle.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic           CLK,
    input  logic           Reset,
    pc_sequencer_if.slave  bus
);

    logic [2:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    strobes_t         strb_raw;
    strobes_t         strb;
    logic             set_illegal;

    pc_seq_decode u_decode (
        .state_i       (state_q),
        .opcode_i      (bus.Opcode),
        .zero_i        (bus.Zero),
        .mem_ready_i   (bus.MemReady),
        .strb_o        (strb_raw),
        .next_state_o  (state_d),
        .set_illegal_o (set_illegal)
    );

    // Kill every strobe while reset is held so nothing fires mid-instruction
    always_comb begin
        strb      = Reset ? '0 : strb_raw;
        illegal_d = illegal_q | set_illegal;
        cnt_d     = strb.PCWrite ? cnt_q + 1'b1 : cnt_q;
    end

    // State, sticky illegal flag and retire counter; reset wins over everything
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IF;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.PCWrite    = strb.PCWrite;
    assign bus.PCSrc      = strb.PCSrc;
    assign bus.IRWrite    = strb.IRWrite;
    assign bus.MemRead    = strb.MemRead;
    assign bus.MemWrite   = strb.MemWrite;
    assign bus.RegWrite   = strb.RegWrite;
    assign bus.RegDst     = strb.RegDst;
    assign bus.MemToReg   = strb.MemToReg;
    assign bus.ALUSrcB    = strb.ALUSrcB;
    assign bus.ALUOp      = strb.ALUOp;
    assign bus.State      = state_q;
    assign bus.Halted     = (state_q == ST_HALT);
    assign bus.Illegal    = illegal_q;
    assign bus.RetiredCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
// One instruction cycle per step; expectations queued at drive time.
// Outputs sampled on the negedge, inputs driven 1ns after the posedge.
module tb_pc_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk;
    logic rst;

    pc_sequencer_if #(.CNT_W(32)) bus ();

    pc_sequencer #(.CNT_W(32)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [13:0] strb;
        logic        halt;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_cnt = 0;
    string       cur = "";

    localparam logic [13:0] Z = 14'd0;

    // Strobe word: {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcB, ALUOp}
    function automatic logic [13:0] mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic mrd, input logic mwr, input logic rw,
                                       input logic [1:0] rd, input logic m2r, input logic asb,
                                       input logic [2:0] aop);
        return {pcw, pcs, irw, mrd, mwr, rw, rd, m2r, asb, aop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare on the negedge
    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mrdy,
                        input logic [2:0] st, input logic [13:0] s, input logic h, input logic il);
        exp_t e;
        logic [13:0] obs;
        rst          = r;
        bus.Opcode   = op;
        bus.Zero     = z;
        bus.MemReady = mrdy;
        e.st = st; e.strb = s; e.halt = h; e.ill = il; e.cnt = model_cnt;
        sb.push_back(e);
        if (r) model_cnt = 0;
        else if (s[13]) model_cnt = model_cnt + 1;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({cur, "/queue"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            obs = {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                   bus.RegDst, bus.MemToReg, bus.ALUSrcB, bus.ALUOp};
            chk({cur, "/state"},  {29'd0, bus.State}, {29'd0, e.st});
            chk({cur, "/strobes"}, {18'd0, obs}, {18'd0, e.strb});
            chk({cur, "/halted"}, {31'd0, bus.Halted}, {31'd0, e.halt});
            chk({cur, "/illegal"}, {31'd0, bus.Illegal}, {31'd0, e.ill});
            chk({cur, "/retired"}, bus.RetiredCnt, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] OP_BAD = 6'b110011;

    logic [13:0] s_if, s_ifw, s_mem_addr;
    logic [5:0]  br_op  [4];
    logic        br_z   [4];
    logic [1:0]  br_src [4];

    initial begin
        s_if       = mk(0, 2'b00, 1, 1, 0, 0, 2'b00, 0, 0, 3'b000);
        s_ifw      = mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 3'b000);
        s_mem_addr = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000);
        br_op[0] = OP_BEQ; br_z[0] = 1'b1; br_src[0] = 2'b01;
        br_op[1] = OP_BEQ; br_z[1] = 1'b0; br_src[1] = 2'b00;
        br_op[2] = OP_BNE; br_z[2] = 1'b1; br_src[2] = 2'b00;
        br_op[3] = OP_BNE; br_z[3] = 1'b0; br_src[3] = 2'b01;

        rst = 1'b1; bus.Opcode = OP_R; bus.Zero = 1'b0; bus.MemReady = 1'b1;
        @(posedge clk); #1;

        cur = "reset";
        step(1, OP_R, 0, 1, ST_IF, Z, 0, 0);

        cur = "R";
        step(0, OP_R, 0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_R, 0, 1, ST_ID,  Z, 0, 0);
        step(0, OP_R, 0, 1, ST_EXE, mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010), 0, 0);
        step(0, OP_R, 0, 1, ST_WB,  mk(1, 2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 3'b000), 0, 0);

        cur = "LW";
        step(0, OP_LW, 0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_LW, 0, 1, ST_ID,  Z, 0, 0);
        step(0, OP_LW, 0, 1, ST_EXE, s_mem_addr, 0, 0);
        step(0, OP_LW, 0, 0, ST_MEM, s_ifw, 0, 0);
        step(0, OP_LW, 0, 0, ST_MEM, s_ifw, 0, 0);
        step(0, OP_LW, 0, 1, ST_MEM, s_ifw, 0, 0);
        step(0, OP_LW, 0, 1, ST_WB,  mk(1, 2'b00, 0, 0, 0, 1, 2'b00, 1, 0, 3'b000), 0, 0);

        for (int i = 0; i < 4; i++) begin
            cur = $sformatf("BR%0d", i);
            step(0, br_op[i], br_z[i], 1, ST_IF,  s_if, 0, 0);
            step(0, br_op[i], br_z[i], 1, ST_ID,  Z, 0, 0);
            step(0, br_op[i], br_z[i], 1, ST_EXE, mk(1, br_src[i], 0, 0, 0, 0, 2'b00, 0, 0, 3'b001), 0, 0);
        end

        cur = "J";
        step(0, OP_J, 0, 1, ST_IF, s_if, 0, 0);
        step(0, OP_J, 0, 1, ST_ID, mk(1, 2'b10, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000), 0, 0);

        cur = "JAL";
        step(0, OP_JAL, 0, 1, ST_IF, s_if, 0, 0);
        step(0, OP_JAL, 0, 1, ST_ID, mk(1, 2'b10, 0, 0, 0, 1, 2'b10, 0, 0, 3'b000), 0, 0);

        cur = "ADDIU";
        step(0, OP_ADDIU, 0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_ADDIU, 0, 0, ST_ID,  Z, 0, 0);
        step(0, OP_ADDIU, 0, 0, ST_EXE, s_mem_addr, 0, 0);
        step(0, OP_ADDIU, 0, 0, ST_WB,  mk(1, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 3'b000), 0, 0);

        cur = "SW";
        step(0, OP_SW, 0, 0, ST_IF,  s_ifw, 0, 0);
        step(0, OP_SW, 0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_SW, 0, 1, ST_ID,  Z, 0, 0);
        step(0, OP_SW, 0, 1, ST_EXE, s_mem_addr, 0, 0);
        step(0, OP_SW, 0, 1, ST_MEM, mk(1, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 3'b000), 0, 0);

        cur = "SWrst";
        step(0, OP_SW, 0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_SW, 0, 1, ST_ID,  Z, 0, 0);
        step(0, OP_SW, 0, 1, ST_EXE, s_mem_addr, 0, 0);
        step(0, OP_SW, 0, 0, ST_MEM, mk(0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 3'b000), 0, 0);
        step(1, OP_SW, 0, 0, ST_MEM, Z, 0, 0);
        step(0, OP_R,  0, 1, ST_IF,  s_if, 0, 0);
        step(0, OP_R,  0, 1, ST_ID,  Z, 0, 0);
        step(0, OP_R,  0, 1, ST_EXE, mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010), 0, 0);
        step(0, OP_R,  0, 1, ST_WB,  mk(1, 2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 3'b000), 0, 0);

        cur = "ILL";
        step(0, OP_BAD, 0, 1, ST_IF, s_if, 0, 0);
        step(0, OP_BAD, 0, 1, ST_ID, Z, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, OP_BAD, i[0], i[1], ST_HALT, Z, 1, 1);
        end
        step(1, OP_BAD, 0, 1, ST_HALT, Z, 1, 1);
        step(0, OP_HALT, 0, 1, ST_IF, s_if, 0, 0);

        cur = "HALT";
        step(0, OP_HALT, 0, 1, ST_ID,   Z, 0, 0);
        step(0, OP_HALT, 0, 1, ST_HALT, Z, 1, 0);
        step(0, OP_HALT, 0, 0, ST_HALT, Z, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
